// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Purpose : one cache-style memory request channel. The same bundle is used
//           for both requester channels and for the shared main-memory port.
// Signals : req_addr     address of the request
//           req_dataout  write data travelling toward memory
//           req_rw       1 = write, 0 = read
//           req_valid    request pending
//           req_ready    one-cycle completion pulse back to the requester
//           req_datain   read data travelling back to the requester
// Modports: master - the side that issues requests (cache controller, or the
//                    arbiter toward main memory)
//           slave  - the side that services requests (the arbiter toward a
//                    cache controller, or main memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_dataout;
    logic              req_rw;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_datain;

    modport master (
        output req_addr,
        output req_dataout,
        output req_rw,
        output req_valid,
        input  req_ready,
        input  req_datain
    );

    modport slave (
        input  req_addr,
        input  req_dataout,
        input  req_rw,
        input  req_valid,
        output req_ready,
        output req_datain
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Purpose : shares one main-memory request port between two cache
//           controllers. Requests are serialised with round-robin fairness,
//           the forwarded request is registered, and the completion plus
//           read data are routed back to the requester that owns the
//           transaction. A watchdog aborts transactions that memory never
//           completes and raises a sticky error flag.
// Ports   : clk       clock, all logic on the rising edge
//           rst_n     synchronous active-low reset
//           r0, r1    requester channels (slave side of the handshake)
//           mem       main-memory channel (master side of the handshake)
//           grant_id  requester currently or last served
//           busy      high whenever the FSM is not idle
//           mem_err   sticky watchdog-abort flag, cleared only by reset
// Params  : ADDR_W, DATA_W   channel widths (must match the interfaces)
//           TIMEOUT_CYC      busy cycles before abort, 0 disables watchdog
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   r0,
    mem_port_arbiter_if.slave   r1,
    mem_port_arbiter_if.master  mem,
    output logic                grant_id,
    output logic                busy,
    output logic                mem_err
);

    // The counter must be able to hold TIMEOUT_CYC itself; a disabled
    // watchdog still keeps a one-bit counter so the logic stays uniform.
    localparam int               CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               WDOG_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state;
    logic              rr_last;
    logic [CNT_W-1:0]  wdog_cnt;

    logic              any_valid;
    logic              sel_port;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_dataout;
    logic              sel_rw;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic              finish_txn;

    // On a tie the port that was not served last wins; a lone request always
    // wins. rr_last starts at 1 so port 0 takes the first tie after reset.
    always_comb begin
        any_valid = r0.req_valid | r1.req_valid;
        if (r0.req_valid && r1.req_valid) begin
            sel_port = ~rr_last;
        end else begin
            sel_port = r1.req_valid;
        end
        sel_addr    = sel_port ? r1.req_addr    : r0.req_addr;
        sel_dataout = sel_port ? r1.req_dataout : r0.req_dataout;
        sel_rw      = sel_port ? r1.req_rw      : r0.req_rw;
    end

    // The counter value after this BUSY edge; it saturates instead of
    // wrapping. The abort fires on the edge where it reaches TIMEOUT_CYC,
    // i.e. the TIMEOUT_CYC-th BUSY edge.
    assign cnt_inc     = (&wdog_cnt) ? wdog_cnt : wdog_cnt + CNT_ONE;
    assign timeout_hit = WDOG_EN && (cnt_inc == TO_VAL);
    assign finish_txn  = mem.req_ready || timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_last         <= 1'b1;
            wdog_cnt        <= '0;
            grant_id        <= 1'b0;
            busy            <= 1'b0;
            mem_err         <= 1'b0;
            mem.req_valid   <= 1'b0;
            mem.req_rw      <= 1'b0;
            mem.req_addr    <= '0;
            mem.req_dataout <= '0;
            r0.req_ready    <= 1'b0;
            r1.req_ready    <= 1'b0;
            r0.req_datain   <= '0;
            r1.req_datain   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        mem.req_addr    <= sel_addr;
                        mem.req_dataout <= sel_dataout;
                        mem.req_rw      <= sel_rw;
                        mem.req_valid   <= 1'b1;
                        grant_id        <= sel_port;
                        wdog_cnt        <= '0;
                        busy            <= 1'b1;
                        state           <= BUSY;
                    end
                end

                BUSY: begin
                    wdog_cnt <= cnt_inc;
                    if (finish_txn) begin
                        mem.req_valid <= 1'b0;
                        // A completion beats a simultaneous timeout; an
                        // aborted read returns zeros instead of stale data.
                        if (!mem.req_rw) begin
                            if (grant_id) begin
                                r1.req_datain <= mem.req_ready ? mem.req_datain : '0;
                            end else begin
                                r0.req_datain <= mem.req_ready ? mem.req_datain : '0;
                            end
                        end
                        if (!mem.req_ready) begin
                            mem_err <= 1'b1;
                        end
                        if (grant_id) begin
                            r1.req_ready <= 1'b1;
                        end else begin
                            r0.req_ready <= 1'b1;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    r0.req_ready <= 1'b0;
                    r1.req_ready <= 1'b0;
                    rr_last      <= grant_id;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Purpose : self-checking bench for mem_port_arbiter. Directed scenarios
//           (single read, write routing, fairness, watchdog, reset during a
//           transaction, stray memory pulses) are followed by randomized
//           traffic, all judged against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 8;

    localparam int DROP = 0;
    localparam int KEEP = 1;
    localparam int RAND = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic grant_id;
    logic busy;
    logic mem_err;

    logic              rq_valid [2];
    logic [ADDR_W-1:0] rq_addr  [2];
    logic              rq_rw    [2];
    logic [DATA_W-1:0] rq_data  [2];
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    int                n_checks = 0;
    int                n_fail   = 0;

    int                rr_last_m;
    logic              exp_grant;
    logic              exp_err;
    logic [DATA_W-1:0] exp_din [2];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_bus ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_bus ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    assign r0_bus.req_valid   = rq_valid[0];
    assign r0_bus.req_addr    = rq_addr[0];
    assign r0_bus.req_rw      = rq_rw[0];
    assign r0_bus.req_dataout = rq_data[0];
    assign r1_bus.req_valid   = rq_valid[1];
    assign r1_bus.req_addr    = rq_addr[1];
    assign r1_bus.req_rw      = rq_rw[1];
    assign r1_bus.req_dataout = rq_data[1];
    assign mem_bus.req_ready  = mem_ready;
    assign mem_bus.req_datain = mem_rdata;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0       (r0_bus),
        .r1       (r1_bus),
        .mem      (mem_bus),
        .grant_id (grant_id),
        .busy     (busy),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic get_rdy(input int p);
        return (p == 0) ? r0_bus.req_ready : r1_bus.req_ready;
    endfunction

    function automatic logic [DATA_W-1:0] get_din(input int p);
        return (p == 0) ? r0_bus.req_datain : r1_bus.req_datain;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input logic v, input logic [ADDR_W-1:0] a,
                                 input logic rw, input logic [DATA_W-1:0] d);
        rq_valid[p] = v;
        rq_addr[p]  = a;
        rq_rw[p]    = rw;
        rq_data[p]  = d;
    endtask

    task automatic new_request(input int p);
        applyStimulus(p, 1'b1, $urandom, 1'($urandom_range(0, 1)),
                      {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic model_reset();
        rr_last_m  = 1;
        exp_grant  = 1'b0;
        exp_err    = 1'b0;
        exp_din[0] = '0;
        exp_din[1] = '0;
    endtask

    task automatic check_data(input string tag);
        checkOutput({tag, "_din0"}, get_din(0), exp_din[0]);
        checkOutput({tag, "_din1"}, get_din(1), exp_din[1]);
    endtask

    task automatic check_reset_state();
        checkOutput("rst_mem_valid", 128'(mem_bus.req_valid), 128'(0));
        checkOutput("rst_mem_rw",    128'(mem_bus.req_rw), 128'(0));
        checkOutput("rst_mem_addr",  128'(mem_bus.req_addr), 128'(0));
        checkOutput("rst_mem_dout",  mem_bus.req_dataout, 128'(0));
        checkOutput("rst_rdy",       128'({get_rdy(1), get_rdy(0)}), 128'(0));
        checkOutput("rst_grant",     128'(grant_id), 128'(0));
        checkOutput("rst_busy",      128'(busy), 128'(0));
        checkOutput("rst_err",       128'(mem_err), 128'(0));
        check_data("rst");
    endtask

    // One full transaction from an idle arbiter with at least one request
    // pending. lat = number of BUSY edges until memory answers; 0 (or any
    // value past TIMEOUT) means memory never answers and the watchdog fires.
    task automatic run_txn(input int lat, input logic [DATA_W-1:0] rdata, input int policy);
        int win;
        int n;
        bit done;
        bit aborted;
        if (rq_valid[0] && rq_valid[1]) begin
            win = (rr_last_m == 0) ? 1 : 0;
        end else begin
            win = rq_valid[1] ? 1 : 0;
        end
        tick();
        exp_grant = win[0];
        checkOutput("grant",     128'(grant_id), 128'(win));
        checkOutput("mem_valid", 128'(mem_bus.req_valid), 128'(1));
        checkOutput("mem_addr",  128'(mem_bus.req_addr), 128'(rq_addr[win]));
        checkOutput("mem_rw",    128'(mem_bus.req_rw), 128'(rq_rw[win]));
        checkOutput("mem_dout",  mem_bus.req_dataout, rq_data[win]);
        checkOutput("busy_on",   128'(busy), 128'(1));
        done    = 1'b0;
        aborted = 1'b0;
        n       = 0;
        while (!done) begin
            n++;
            mem_ready = (lat == n);
            mem_rdata = (lat == n) ? rdata : {$urandom, $urandom, $urandom, $urandom};
            tick();
            aborted = (lat != n) && (n == TIMEOUT);
            if (lat == n || aborted) begin
                done = 1'b1;
            end else begin
                checkOutput("busy_hold",    128'(mem_bus.req_valid), 128'(1));
                checkOutput("no_early_rdy", 128'({get_rdy(1), get_rdy(0)}), 128'(0));
            end
        end
        mem_ready = 1'b0;
        if (!rq_rw[win]) begin
            exp_din[win] = aborted ? '0 : rdata;
        end
        if (aborted) begin
            exp_err = 1'b1;
        end
        checkOutput("rdy_win",   128'(get_rdy(win)), 128'(1));
        checkOutput("rdy_other", 128'(get_rdy(1 - win)), 128'(0));
        checkOutput("mem_drop",  128'(mem_bus.req_valid), 128'(0));
        checkOutput("err",       128'(mem_err), 128'(exp_err));
        check_data("done");
        // The served requester reacts in the response cycle; a memory pulse
        // here must be ignored.
        if (policy == DROP || (policy == RAND && $urandom_range(0, 1) == 0)) begin
            rq_valid[win] = 1'b0;
        end else begin
            new_request(win);
        end
        mem_ready = 1'($urandom_range(0, 1));
        tick();
        mem_ready = 1'b0;
        rr_last_m = win;
        checkOutput("rdy_pulse", 128'({get_rdy(1), get_rdy(0)}), 128'(0));
        checkOutput("idle_busy", 128'(busy), 128'(0));
        checkOutput("idle_mem",  128'(mem_bus.req_valid), 128'(0));
        checkOutput("idle_err",  128'(mem_err), 128'(exp_err));
        check_data("idle");
    endtask

    // An idle cycle with no requests, optionally with a stray memory pulse.
    task automatic idle_cycle(input logic stray);
        mem_ready = stray;
        tick();
        mem_ready = 1'b0;
        checkOutput("stray_busy",  128'(busy), 128'(0));
        checkOutput("stray_mem",   128'(mem_bus.req_valid), 128'(0));
        checkOutput("stray_rdy",   128'({get_rdy(1), get_rdy(0)}), 128'(0));
        checkOutput("stray_grant", 128'(grant_id), 128'(exp_grant));
        check_data("stray");
    endtask

    initial begin
        int lat;
        int r;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int p = 0; p < 2; p++) begin
            applyStimulus(p, 1'b0, '0, 1'b0, '0);
        end
        model_reset();
        tick();
        tick();
        check_reset_state();
        rst_n = 1'b1;

        $display("[TB] single read");
        applyStimulus(0, 1'b1, 32'h0000_0040, 1'b0, '0);
        run_txn(2, 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF, DROP);

        $display("[TB] write-back routing");
        applyStimulus(1, 1'b1, 32'h0001_0000, 1'b1, {16{8'hA5}});
        run_txn(3, {$urandom, $urandom, $urandom, $urandom}, DROP);

        $display("[TB] simultaneous requests");
        new_request(0);
        new_request(1);
        for (int i = 0; i < 4; i++) begin
            run_txn($urandom_range(1, 4), {$urandom, $urandom, $urandom, $urandom},
                    (i < 2) ? KEEP : DROP);
            checkOutput("alt_grant", 128'(grant_id), 128'(i % 2));
        end

        $display("[TB] watchdog");
        applyStimulus(0, 1'b1, 32'h0000_2000, 1'b0, '0);
        run_txn(0, '0, DROP);
        idle_cycle(1'b0);
        checkOutput("err_sticky", 128'(mem_err), 128'(1));
        applyStimulus(1, 1'b1, 32'h0000_3000, 1'b0, '0);
        run_txn(3, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_9BDF, DROP);
        checkOutput("err_stays", 128'(mem_err), 128'(1));

        $display("[TB] reset mid-operation");
        new_request(0);
        new_request(1);
        tick();
        checkOutput("mid_busy", 128'(busy), 128'(1));
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        check_reset_state();
        run_txn(3, {$urandom, $urandom, $urandom, $urandom}, DROP);
        checkOutput("tie_after_rst", 128'(grant_id), 128'(0));
        run_txn(2, {$urandom, $urandom, $urandom, $urandom}, DROP);

        $display("[TB] stray memory pulses");
        for (int i = 0; i < 3; i++) begin
            idle_cycle(1'b1);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 80; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq_valid[p] && $urandom_range(0, 2) != 0) begin
                    new_request(p);
                end
            end
            if (!rq_valid[0] && !rq_valid[1]) begin
                idle_cycle(1'($urandom_range(0, 1)));
            end else begin
                r   = $urandom_range(0, 15);
                lat = (r == 0) ? 0 :
                      (r == 1) ? TIMEOUT :
                      (r == 2) ? TIMEOUT + 3 : $urandom_range(1, 5);
                run_txn(lat, {$urandom, $urandom, $urandom, $urandom}, RAND);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single 128-bit main-memory request port between two cache controllers (e.g. I-cache on port 0, D-cache on port 1). Each requester uses the same `mem_req_*` handshake the cache controller already drives. The arbiter serialises requests with round-robin fairness, registers the forwarded request and routes the completion and read data back to the owning requester. A watchdog aborts transactions that memory never completes.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 128, cache-line data width
- `TIMEOUT_CYC`, 1024, maximum BUSY cycles before abort; 0 disables the watchdog
- `clk`  in  1  clock; all logic on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `r0_req_addr`, `r1_req_addr`  in  ADDR_W  requester address
- `r0_req_dataout`, `r1_req_dataout`  in  DATA_W  requester write data
- `r0_req_rw`, `r1_req_rw`  in  1  1 = write, 0 = read
- `r0_req_valid`, `r1_req_valid`  in  1  request pending
- `r0_req_ready`, `r1_req_ready`  out  1  one-cycle completion pulse
- `r0_req_datain`, `r1_req_datain`  out  DATA_W  read data returned to the requester
- `mem_req_addr`  out  ADDR_W  forwarded address (registered)
- `mem_req_dataout`  out  DATA_W  forwarded write data (registered)
- `mem_req_rw`  out  1  forwarded direction (registered)
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory completion pulse; read data is valid on `mem_req_datain` in the same cycle
- `mem_req_datain`  in  DATA_W  memory read data
- `grant_id`  out  1  requester currently or last served
- `busy`  out  1  high whenever the FSM is not in IDLE
- `mem_err`  out  1  sticky watchdog-abort flag

## Operation
- Requester contract:
  - Hold `valid`, `addr`, `rw` and `dataout` stable until its `ready` pulse.
  - In the cycle after `ready`, either drop `valid` or present a new request.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - With no request pending, stay in IDLE.
  - With one or both requests pending, select by round-robin. Priority goes to the requester not equal to `rr_last`; `rr_last` resets to 1, so port 0 wins the first tie.
  - On the transition edge: register the selected fields into `mem_req_*`, set `mem_req_valid`, set `grant_id` to the selected port, clear the watchdog counter, go to BUSY.
- BUSY:
  - `mem_req_valid` stays high and the request fields are frozen.
  - Requester inputs are not sampled.
  - The watchdog counter increments every cycle.
  - On `mem_req_ready`:
    - drop `mem_req_valid`;
    - if `mem_req_rw` = 0, load `mem_req_datain` into `rN_req_datain` of the granted port;
    - set the granted `rN_req_ready`;
    - go to RESP.
  - Watchdog abort: when the counter reaches `TIMEOUT_CYC` (nonzero) without `mem_req_ready`:
    - drop `mem_req_valid`;
    - load 0 into `rN_req_datain` for reads;
    - set `mem_err` and the granted `rN_req_ready`;
    - go to RESP.
  - If `mem_req_ready` and timeout occur in the same cycle, the completion wins and `mem_err` is not set.
- RESP:
  - `rN_req_ready` is high for exactly this cycle.
  - `rr_last` is set to `grant_id`.
  - Next state is IDLE unconditionally.
  - Valid on either port is ignored in this cycle.
- Data rules:
  - `rN_req_datain` changes only on a read completion or abort for port N; otherwise it holds.
  - Write completions do not alter it.
- `mem_req_ready` is ignored outside BUSY.
- Watchdog counter width is `$clog2(TIMEOUT_CYC+1)`, minimum 1. It saturates and never wraps.

## Timing
- Reset: on any posedge with `rst_n` = 0, the block enters IDLE regardless of state, and any in-flight memory transaction is abandoned with no `ready` to the requester. Reset values:
  - `mem_req_valid`, `mem_req_rw`, both `ready` = 0;
  - `mem_req_addr`, `mem_req_dataout`, both `datain` = 0;
  - `grant_id` = 0, `busy` = 0, `mem_err` = 0;
  - `rr_last` = 1.
- Request latency: valid sampled at edge T gives `mem_req_valid` = 1 after edge T.
- Memory completion: `mem_req_ready` sampled at edge T+k gives `rN_req_ready` = 1 from edge T+k to edge T+k+1. The FSM is back in IDLE after edge T+k+1.
- Minimum service time is 3 cycles per transaction (IDLE, BUSY, RESP). Back-to-back grants are therefore separated by one IDLE cycle.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…; neither port waits more than one transaction.
- Abort timing: `TIMEOUT_CYC` = N means abort at the N-th BUSY cycle edge. `mem_err` stays 1 until reset.

## Test plan
- **Single read:** reset, then r0 read at 0x0000_0040; memory returns `ready` 2 cycles later with data 0x…DEADBEEF. Required: `mem_req_addr` = 0x40, `rw` = 0; `r0_req_ready` is a single-cycle pulse; `r0_req_datain` = 0x…DEADBEEF; `r1_req_ready` never asserts.
- **Simultaneous requests:** r0 and r1 valid in the same cycle after reset, 4 transactions held. Required: `grant_id` sequence 0,1,0,1; each `ready` goes to the matching port.
- **Write-back routing:** r1 write at 0x0001_0000 with data 0xA5…A5. Required: `mem_req_dataout` = 0xA5…A5, `mem_req_rw` = 1, `r1_req_ready` pulses, `r1_req_datain` unchanged.
- **Watchdog:** `TIMEOUT_CYC` = 8, r0 read, memory never responds. Required: `mem_req_valid` drops after 8 BUSY cycles; `r0_req_ready` pulses with `r0_req_datain` = 0; `mem_err` = 1 and stays high. A subsequent r1 read with a normal completion succeeds.
- **Reset mid-operation:** assert `rst_n` = 0 while in BUSY. Required: next edge `mem_req_valid` = 0, `busy` = 0, no `ready` pulse, `mem_err` = 0. After release, the first simultaneous tie is granted to port 0.
- **Stray memory pulse:** pulse `mem_req_ready` while in IDLE. Required: no `ready` output and no state change.
